// File: rtl/mem_loader_pkg.sv
// Shared types for the byte-stream image loader and its read window.
package mem_loader_pkg;

    // Encodings are fixed so firmware/debug tools can decode the state.
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DONE  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/mem_window.sv
// Combinational byte-window extraction plus legality check for a byte memory.
// The first requested byte lands in the top byte lane; unused lanes are zero.
module mem_window
    import mem_loader_pkg::*;
#(
    parameter int AW    = 6,
    parameter int DW    = 8,
    parameter int EXTRA = 4
) (
    input  logic [2**(AW+1)-1:0][DW-1:0] mem_i,
    input  logic                         done_i,
    input  logic [AW+1:0]                count_i,
    input  logic [AW:0]                  addr_i,
    input  logic [EXTRA-1:0]             extra_i,
    input  logic [AW:0]                  lower_i,
    input  logic [AW:0]                  upper_i,
    output logic [(2**EXTRA)*DW-1:0]     data_o,
    output logic                         error_o
);

    localparam int NB = 2**EXTRA;
    localparam int CW = AW + 2;

    logic [CW-1:0]         end_addr;
    logic [AW:0]           pos;
    logic [NB*DW-1:0]      win;

    // End address is one bit wider than the address so it can never wrap.
    assign end_addr = {1'b0, addr_i} + CW'(extra_i);

    always_comb begin
        error_o = 1'b0;
        if (!done_i)
            error_o = 1'b1;
        if (addr_i < lower_i)
            error_o = 1'b1;
        if (end_addr > {1'b0, upper_i})
            error_o = 1'b1;
        if (end_addr >= count_i)
            error_o = 1'b1;
    end

    always_comb begin
        win = '0;
        pos = '0;
        for (int k = 0; k < NB; k++) begin
            pos = addr_i + (AW+1)'(k);
            if (k <= int'(extra_i))
                win[(NB-1-k)*DW +: DW] = mem_i[pos];
        end
    end

    assign data_o = error_o ? '0 : win;

endmodule

// File: rtl/mem_loader.sv
// Streams a byte image into local memory, then serves registered byte-window reads.
// Reads: 1-cycle latency, no handshake; loading stops accepting once DONE or FAULT.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int AW    = 6,
    parameter int DW    = 8,
    parameter int EXTRA = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DW-1:0]            in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     loaded,
    output logic [AW+1:0]            load_count,
    input  logic [AW:0]              addr,
    input  logic [EXTRA-1:0]         extra,
    input  logic [AW:0]              lower_bound,
    input  logic [AW:0]              upper_bound,
    output logic [(2**EXTRA)*DW-1:0] data,
    output logic                     error
);

    localparam int DEPTH = 2**(AW+1);
    localparam logic [AW+1:0] FULL_CNT = {1'b1, {(AW+1){1'b0}}};

    state_t                       state_q;
    logic [AW+1:0]                count_q;
    logic                         in_ready_q;
    logic                         loaded_q;
    logic [(2**EXTRA)*DW-1:0]     data_q;
    logic                         error_q;
    logic [DEPTH-1:0][DW-1:0]     mem_q;

    logic                         wr_en;
    logic [(2**EXTRA)*DW-1:0]     data_d;
    logic                         error_d;

    assign wr_en = in_valid && (state_q == ST_LOAD) && !reset && (count_q != FULL_CNT);

    // The array has no reset: a reset mid-load only rewinds the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[count_q[AW:0]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            loaded_q   <= 1'b0;
            data_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            data_q  <= data_d;
            error_q <= error_d;
            case (state_q)
                ST_LOAD: begin
                    if (in_valid) begin
                        if (count_q == FULL_CNT) begin
                            state_q    <= ST_FAULT;
                            in_ready_q <= 1'b0;
                        end else begin
                            count_q <= count_q + (AW+2)'(1);
                            if (in_last) begin
                                state_q    <= ST_DONE;
                                in_ready_q <= 1'b0;
                                loaded_q   <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The window sees the pre-edge state, so a read on the completing edge still faults.
    mem_window #(
        .AW    (AW),
        .DW    (DW),
        .EXTRA (EXTRA)
    ) u_window (
        .mem_i   (mem_q),
        .done_i  (state_q == ST_DONE),
        .count_i (count_q),
        .addr_i  (addr),
        .extra_i (extra),
        .lower_i (lower_bound),
        .upper_i (upper_bound),
        .data_o  (data_d),
        .error_o (error_d)
    );

    assign in_ready   = in_ready_q;
    assign loaded     = loaded_q;
    assign load_count = count_q;
    assign data       = data_q;
    assign error      = error_q;

endmodule
